multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//   Moore-style FSM controller that sequences the MIPS datapath over several cycles per
//   instruction (FETCH/DECODE/EXEC/MEM/WB) instead of one. Drives IR/PC/GRF/DM write strobes
//   and the datapath mux/ALU selects. Holds a retired-instruction counter.
//   Sits beside IFU/GRF/ALU/DM/NPC/EXT. The IR and PC registers sit outside this block.
// PARAMETERS
//   CNT_W    32   width of retired-instruction counter
// PORTS
//   clk          in   1      system clock, all state changes on posedge
//   reset        in   1      synchronous, active-high
//   opcode       in   6      IR[31:26], stable from the cycle after IRWrite
//   funct        in   6      IR[5:0]
//   Zero         in   1      ALU equality flag (rs==rt), valid in EXEC
//   MemReady     in   1      DM access complete; sampled only in MEM
//   IRWrite      out  1      load IR from IM
//   PCWrite      out  1      load PC <- NPC (exactly one pulse per instruction)
//   RegWrite     out  1      GRF write enable
//   MemWrite     out  1      DM write enable
//   ALUControl   out  3      0 add, 1 sub, 2 or
//   ALUSrc       out  1      0 RD2, 1 EXTImm32
//   EXTControl   out  3      0 zero-ext, 1 sign-ext, 2 imm<<16
//   RegDst       out  2      0 rt, 1 rd, 2 $31
//   Mem2Reg      out  3      0 ALU result, 1 MemReadData, 2 EXTImm32, 3 PC4
//   NPCControl   out  3      0 PC+4, 1 branch, 2 j/jal, 3 jr
//   State        out  3      0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB
//   InstrDone    out  1      1-cycle pulse, same cycle as PCWrite
//   RetireCnt    out  CNT_W  count of completed instructions
// BEHAVIOUR
//   Reset: State=FETCH, RetireCnt=0, decoded class=NOP.
//     While reset=1, every strobe (IRWrite, PCWrite, RegWrite, MemWrite, InstrDone) is 0.
//     Reset mid-instruction abandons it. No PC/GRF/DM write occurs for the abandoned instruction.
//   FETCH: IRWrite=1. Next state DECODE.
//   DECODE: latch class from opcode/funct.
//     Class encodings:
//       ADDU 000000/100001, SUBU 000000/100011, JR 000000/001000, NOP (any other op 0 funct)
//       ORI 001101, LUI 001111, LW 100011, SW 101011, BEQ 000100, JAL 000011
//     Any unlisted opcode is decoded as NOP.
//     The latched class drives all later states, so IR changes after DECODE are ignored.
//     Next state:
//       NOP, JR: retire in DECODE, then FETCH.
//       JAL: WB.
//       All other classes: EXEC.
//   Per-class state sequence, selects and cycle counts:
//     ADDU/SUBU  F,D,E,WB  4 cycles   ALUSrc=0, ALU=add/sub, RegDst=1, Mem2Reg=0
//     ORI        F,D,E,WB  4 cycles   ALUSrc=1, EXT=0, ALU=or, RegDst=0, Mem2Reg=0
//     LUI        F,D,E,WB  4 cycles   EXT=2, RegDst=0, Mem2Reg=2
//     LW         F,D,E,M,WB  5+ cycles  ALUSrc=1, EXT=1, ALU=add, RegDst=0, Mem2Reg=1
//     SW         F,D,E,M   4+ cycles  ALUSrc=1, EXT=1, ALU=add; MemWrite=1 throughout MEM
//     BEQ        F,D,E     3 cycles   ALUSrc=0, ALU=sub, EXT=1; NPCControl=Zero?1:0 in E
//     JAL        F,D,WB    3 cycles   RegDst=2, Mem2Reg=3, NPCControl=2
//     JR         F,D       2 cycles   NPCControl=3
//     NOP        F,D       2 cycles   NPCControl=0
//   NPCControl is 0 in every cycle not listed above.
//   Write strobes:
//     RegWrite=1 only in the WB cycle.
//     PCWrite and InstrDone=1 only in the last state of the instruction.
//     For MEM, the last cycle is the one where MemReady=1.
//     PC4 seen by WB (JAL) must be the PC of the current instruction + 4, because PC is not yet updated.
//   MEM wait state:
//     State stays MEM while MemReady=0, with all strobes and selects held.
//     MemWrite stays asserted; DM accepts the write when MemReady=1.
//     LW: MemReady=1 -> WB.
//     SW: MemReady=1 -> retire -> FETCH. There is no timeout.
//   Selects hold their value for the whole instruction: they are a function of the latched
//     class and do not glitch between states.
//   RetireCnt increments by 1 on each InstrDone and wraps 2^CNT_W-1 -> 0.
// TESTING
//   - Reset mid-LW while in MEM -> next cycle State=0 with IRWrite=1. No RegWrite and no PCWrite pulse. RetireCnt=0.
//   - ADDU, ORI, LUI (0x3c01ffff) -> each 4 cycles; InstrDone at cycles 4, 8, 12; RegDst=1, 0, 0; Mem2Reg=0, 0, 2.
//   - SW with MemReady low for 3 cycles -> MEM held 4 cycles, MemWrite=1 for all 4, PCWrite only on the last; 7 cycles total.
//   - BEQ with Zero=1 -> NPCControl=1 with PCWrite in cycle 3. With Zero=0 -> NPCControl=0; 3 cycles either way.
//   - JAL then JR $31 -> RegWrite with RegDst=2, Mem2Reg=3 in cycle 3; JR retires in 2 cycles with NPCControl=3.
//   - Opcode 0x3f (unknown) -> treated as NOP, 2 cycles, no RegWrite/MemWrite. With CNT_W=4, 16 NOPs wrap RetireCnt to 0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and the MIPS datapath.
// The controller drives the strobes and selects; the datapath returns IR fields and status flags.
interface multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             Zero;
  logic             MemReady;
  logic             IRWrite;
  logic             PCWrite;
  logic             RegWrite;
  logic             MemWrite;
  logic [2:0]       ALUControl;
  logic             ALUSrc;
  logic [2:0]       EXTControl;
  logic [1:0]       RegDst;
  logic [2:0]       Mem2Reg;
  logic [2:0]       NPCControl;
  logic [2:0]       State;
  logic             InstrDone;
  logic [CNT_W-1:0] RetireCnt;

  modport master (
    input  opcode, funct, Zero, MemReady,
    output IRWrite, PCWrite, RegWrite, MemWrite, ALUControl, ALUSrc, EXTControl,
           RegDst, Mem2Reg, NPCControl, State, InstrDone, RetireCnt
  );

  modport slave (
    output opcode, funct, Zero, MemReady,
    input  IRWrite, PCWrite, RegWrite, MemWrite, ALUControl, ALUSrc, EXTControl,
           RegDst, Mem2Reg, NPCControl, State, InstrDone, RetireCnt
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore-style multicycle MIPS controller: FETCH/DECODE/EXEC/MEM/WB sequencing,
// datapath strobes and selects, and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    C_NOP  = 4'd0,
    C_ADDU = 4'd1,
    C_SUBU = 4'd2,
    C_JR   = 4'd3,
    C_ORI  = 4'd4,
    C_LUI  = 4'd5,
    C_LW   = 4'd6,
    C_SW   = 4'd7,
    C_BEQ  = 4'd8,
    C_JAL  = 4'd9
  } class_e;

  state_e           state_q, state_d;
  class_e           class_q, class_d;
  class_e           dec_class;
  class_e           cur_class;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       ir_w, pc_w, reg_w, mem_w;
  logic [2:0] npc_sel;

  function automatic class_e decode(input logic [5:0] op, input logic [5:0] fn);
    class_e c;
    c = C_NOP;
    case (op)
      6'b000000: begin
        case (fn)
          6'b100001: c = C_ADDU;
          6'b100011: c = C_SUBU;
          6'b001000: c = C_JR;
          default:   c = C_NOP;
        endcase
      end
      6'b001101: c = C_ORI;
      6'b001111: c = C_LUI;
      6'b100011: c = C_LW;
      6'b101011: c = C_SW;
      6'b000100: c = C_BEQ;
      6'b000011: c = C_JAL;
      default:   c = C_NOP;
    endcase
    return c;
  endfunction

  // DECODE acts on the live IR fields; every later state uses the class latched at the end of DECODE.
  always_comb begin
    dec_class = decode(bus.opcode, bus.funct);
    cur_class = (state_q == S_DECODE) ? dec_class : class_q;
    class_d   = (state_q == S_DECODE) ? dec_class : class_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      class_q <= C_NOP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_w    = 1'b0;
    pc_w    = 1'b0;
    reg_w   = 1'b0;
    mem_w   = 1'b0;
    npc_sel = 3'd0;
    case (state_q)
      S_FETCH: begin
        ir_w    = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (cur_class)
          C_NOP: begin
            pc_w    = 1'b1;
            state_d = S_FETCH;
          end
          C_JR: begin
            pc_w    = 1'b1;
            npc_sel = 3'd3;
            state_d = S_FETCH;
          end
          C_JAL: begin
            npc_sel = 3'd2;
            state_d = S_WB;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cur_class)
          C_BEQ: begin
            npc_sel = bus.Zero ? 3'd1 : 3'd0;
            pc_w    = 1'b1;
            state_d = S_FETCH;
          end
          C_LW, C_SW:                    state_d = S_MEM;
          C_ADDU, C_SUBU, C_ORI, C_LUI:  state_d = S_WB;
          default:                       state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_w = (cur_class == C_SW);
        if (bus.MemReady) begin
          if (cur_class == C_LW) begin
            state_d = S_WB;
          end else begin
            pc_w    = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_w   = 1'b1;
        pc_w    = 1'b1;
        npc_sel = (cur_class == C_JAL) ? 3'd2 : 3'd0;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (pc_w) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Selects depend only on the instruction class, so they stay flat across its states.
  always_comb begin
    bus.ALUControl = 3'd0;
    bus.ALUSrc     = 1'b0;
    bus.EXTControl = 3'd0;
    bus.RegDst     = 2'd0;
    bus.Mem2Reg    = 3'd0;
    case (cur_class)
      C_ADDU: begin
        bus.ALUControl = 3'd0;
        bus.RegDst     = 2'd1;
      end
      C_SUBU: begin
        bus.ALUControl = 3'd1;
        bus.RegDst     = 2'd1;
      end
      C_ORI: begin
        bus.ALUSrc     = 1'b1;
        bus.EXTControl = 3'd0;
        bus.ALUControl = 3'd2;
      end
      C_LUI: begin
        bus.EXTControl = 3'd2;
        bus.Mem2Reg    = 3'd2;
      end
      C_LW: begin
        bus.ALUSrc     = 1'b1;
        bus.EXTControl = 3'd1;
        bus.Mem2Reg    = 3'd1;
      end
      C_SW: begin
        bus.ALUSrc     = 1'b1;
        bus.EXTControl = 3'd1;
      end
      C_BEQ: begin
        bus.ALUControl = 3'd1;
        bus.EXTControl = 3'd1;
      end
      C_JAL: begin
        bus.RegDst  = 2'd2;
        bus.Mem2Reg = 3'd3;
      end
      default: ;
    endcase
  end

  // Strobes are forced low while reset is held so an abandoned instruction never writes.
  always_comb begin
    bus.IRWrite    = ir_w  & ~reset;
    bus.PCWrite    = pc_w  & ~reset;
    bus.RegWrite   = reg_w & ~reset;
    bus.MemWrite   = mem_w & ~reset;
    bus.InstrDone  = pc_w  & ~reset;
    bus.NPCControl = npc_sel;
    bus.State      = state_q;
    bus.RetireCnt  = cnt_q;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl (CNT_W=4 so the counter wrap is reachable).
module tb_multicycle_ctrl;

  logic clk;
  logic reset;

  multicycle_ctrl_if #(.CNT_W(4)) bus();

  multicycle_ctrl #(.CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mask bits: [5] ALUControl [4] ALUSrc [3] EXTControl [2] RegDst [1] Mem2Reg [0] NPCControl
  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zero;
    int unsigned wait_n;
    int unsigned cycles;
    int unsigned regw;
    int unsigned memw;
    logic [5:0]  mask;
    logic [2:0]  alu;
    logic        alusrc;
    logic [2:0]  ext;
    logic [1:0]  regdst;
    logic [2:0]  m2r;
    logic [2:0]  npc;
  } vec_t;

  vec_t vecs[15];
  vec_t nop_v;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [3:0]  exp_cnt = 4'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge with the DUT in FETCH; returns at the negedge after the instruction retires.
  task automatic run_vec(input vec_t v);
    int unsigned cyc, done_at, mem_n, irw, pcw, rw, rw_bad, mw, pc_ne_done, dn;
    logic [2:0] alu_s, ext_s, m2r_s, npc_s;
    logic       alusrc_s;
    logic [1:0] regdst_s;
    cyc = 0; done_at = 0; mem_n = 0; irw = 0; pcw = 0; rw = 0; rw_bad = 0;
    mw = 0; pc_ne_done = 0; dn = 0;
    alu_s = '0; ext_s = '0; m2r_s = '0; npc_s = '0; alusrc_s = 1'b0; regdst_s = '0;
    bus.opcode   = v.op;
    bus.funct    = v.fn;
    bus.Zero     = v.zero;
    bus.MemReady = 1'b0;
    while (done_at == 0 && cyc < 30) begin
      cyc++;
      if (bus.State == 3'd3) begin
        bus.MemReady = (mem_n >= v.wait_n);
        mem_n++;
      end else begin
        bus.MemReady = 1'b0;
      end
      #1;
      if (bus.IRWrite)   irw++;
      if (bus.PCWrite)   pcw++;
      if (bus.InstrDone) dn++;
      if (bus.RegWrite)  rw++;
      if (bus.RegWrite && bus.State != 3'd4) rw_bad++;
      if (bus.MemWrite)  mw++;
      if (bus.PCWrite != bus.InstrDone) pc_ne_done++;
      if (bus.InstrDone) begin
        done_at  = cyc;
        alu_s    = bus.ALUControl;
        alusrc_s = bus.ALUSrc;
        ext_s    = bus.EXTControl;
        regdst_s = bus.RegDst;
        m2r_s    = bus.Mem2Reg;
        npc_s    = bus.NPCControl;
      end
      // IR contents after DECODE must not matter
      if (cyc >= 3) begin
        bus.opcode = ~v.op;
        bus.funct  = ~v.fn;
      end
      @(negedge clk);
    end
    bus.MemReady = 1'b0;
    exp_cnt = exp_cnt + 4'd1;
    check({v.name, " cycles"}, done_at, v.cycles);
    check({v.name, " IRWrite pulses"}, irw, 1);
    check({v.name, " PCWrite pulses"}, pcw, 1);
    check({v.name, " InstrDone pulses"}, dn, 1);
    check({v.name, " PCWrite!=InstrDone cycles"}, pc_ne_done, 0);
    check({v.name, " RegWrite cycles"}, rw, v.regw);
    check({v.name, " RegWrite outside WB"}, rw_bad, 0);
    check({v.name, " MemWrite cycles"}, mw, v.memw);
    check({v.name, " RetireCnt"}, bus.RetireCnt, exp_cnt);
    check({v.name, " State after retire"}, bus.State, 0);
    if (v.mask[5]) check({v.name, " ALUControl"}, alu_s, v.alu);
    if (v.mask[4]) check({v.name, " ALUSrc"}, alusrc_s, v.alusrc);
    if (v.mask[3]) check({v.name, " EXTControl"}, ext_s, v.ext);
    if (v.mask[2]) check({v.name, " RegDst"}, regdst_s, v.regdst);
    if (v.mask[1]) check({v.name, " Mem2Reg"}, m2r_s, v.m2r);
    if (v.mask[0]) check({v.name, " NPCControl"}, npc_s, v.npc);
    bus.opcode = 6'd0;
    bus.funct  = 6'd0;
  endtask

  initial begin
    int unsigned k, pcw, rw, n;
    //          name       op         fn         z  wt cyc rw mw mask       alu   src   ext   dst   m2r   npc
    vecs[0]  = '{"ADDU",   6'h00, 6'b100001, 1'b0, 0, 4, 1, 0, 6'b110111, 3'd0, 1'b0, 3'd0, 2'd1, 3'd0, 3'd0};
    vecs[1]  = '{"ORI",    6'h0d, 6'h12,     1'b0, 0, 4, 1, 0, 6'b111111, 3'd2, 1'b1, 3'd0, 2'd0, 3'd0, 3'd0};
    vecs[2]  = '{"LUI",    6'h0f, 6'h3f,     1'b0, 0, 4, 1, 0, 6'b001111, 3'd0, 1'b0, 3'd2, 2'd0, 3'd2, 3'd0};
    vecs[3]  = '{"SUBU",   6'h00, 6'b100011, 1'b1, 0, 4, 1, 0, 6'b110111, 3'd1, 1'b0, 3'd0, 2'd1, 3'd0, 3'd0};
    vecs[4]  = '{"LW0",    6'h23, 6'h00,     1'b0, 0, 5, 1, 0, 6'b111111, 3'd0, 1'b1, 3'd1, 2'd0, 3'd1, 3'd0};
    vecs[5]  = '{"LW2",    6'h23, 6'h05,     1'b0, 2, 7, 1, 0, 6'b111111, 3'd0, 1'b1, 3'd1, 2'd0, 3'd1, 3'd0};
    vecs[6]  = '{"SW3",    6'h2b, 6'h00,     1'b0, 3, 7, 0, 4, 6'b111001, 3'd0, 1'b1, 3'd1, 2'd0, 3'd0, 3'd0};
    vecs[7]  = '{"SW0",    6'h2b, 6'h21,     1'b0, 0, 4, 0, 1, 6'b111001, 3'd0, 1'b1, 3'd1, 2'd0, 3'd0, 3'd0};
    vecs[8]  = '{"BEQZ1",  6'h04, 6'h00,     1'b1, 0, 3, 0, 0, 6'b111001, 3'd1, 1'b0, 3'd1, 2'd0, 3'd0, 3'd1};
    vecs[9]  = '{"BEQZ0",  6'h04, 6'h00,     1'b0, 0, 3, 0, 0, 6'b111001, 3'd1, 1'b0, 3'd1, 2'd0, 3'd0, 3'd0};
    vecs[10] = '{"JAL",    6'h03, 6'h00,     1'b0, 0, 3, 1, 0, 6'b000111, 3'd0, 1'b0, 3'd0, 2'd2, 3'd3, 3'd2};
    vecs[11] = '{"JR",     6'h00, 6'b001000, 1'b0, 0, 2, 0, 0, 6'b000001, 3'd0, 1'b0, 3'd0, 2'd0, 3'd0, 3'd3};
    vecs[12] = '{"OP3F",   6'h3f, 6'h21,     1'b0, 0, 2, 0, 0, 6'b000001, 3'd0, 1'b0, 3'd0, 2'd0, 3'd0, 3'd0};
    vecs[13] = '{"SLLNOP", 6'h00, 6'h00,     1'b0, 0, 2, 0, 0, 6'b000001, 3'd0, 1'b0, 3'd0, 2'd0, 3'd0, 3'd0};
    vecs[14] = '{"F25NOP", 6'h00, 6'h25,     1'b1, 0, 2, 0, 0, 6'b000001, 3'd0, 1'b0, 3'd0, 2'd0, 3'd0, 3'd0};
    nop_v = vecs[12];

    reset = 1'b1;
    bus.opcode = 6'd0; bus.funct = 6'd0; bus.Zero = 1'b0; bus.MemReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset State", bus.State, 0);
    check("reset RetireCnt", bus.RetireCnt, 0);
    check("reset IRWrite gated", bus.IRWrite, 0);
    reset = 1'b0;

    // Reset while an LW is stalled in MEM
    bus.opcode = 6'h23;
    k = 0; pcw = 0; rw = 0;
    while (bus.State != 3'd3 && k < 10) begin
      #1;
      if (bus.PCWrite)  pcw++;
      if (bus.RegWrite) rw++;
      @(negedge clk);
      k++;
    end
    check("rstLW reached MEM", bus.State, 3);
    repeat (2) begin
      #1;
      if (bus.PCWrite)  pcw++;
      if (bus.RegWrite) rw++;
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    check("rstLW strobes low in reset",
          {27'd0, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.InstrDone}, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.opcode = 6'd0;
    #1;
    check("rstLW State", bus.State, 0);
    check("rstLW IRWrite", bus.IRWrite, 1);
    check("rstLW RetireCnt", bus.RetireCnt, 0);
    check("rstLW RegWrite pulses", rw, 0);
    check("rstLW PCWrite pulses", pcw, 0);
    @(negedge clk);
    // DUT is in DECODE of a NOP here; let it retire, then realign on FETCH
    #1;
    check("rstLW follow-on NOP retire", bus.InstrDone, 1);
    exp_cnt = exp_cnt + 4'd1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i]);
    end

    // Run NOPs until the 4-bit counter wraps to zero
    n = 16 - int'(exp_cnt);
    for (int i = 0; i < int'(n); i++) begin
      run_vec(nop_v);
    end
    check("wrap RetireCnt", bus.RetireCnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
